router_out_arbiter: RTL and testbench
=====================================

# router_out_arbiter

Packet-level round-robin arbiter that merges the three destination FIFOs of the 1x3 router onto one shared 8-bit output stream. It grants one FIFO at a time for a whole packet (header, payload, parity), tracks packet length from the header, and drives the FIFO read enables. A stall watchdog aborts a stuck packet and pulses that FIFO's soft reset.

## Interface
- TIMEOUT, 30, consecutive non-transfer cycles inside a packet before abort (1..255)
- clock  in  1  single clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- empty_0 / empty_1 / empty_2  in  1  FIFO x empty
- data_out_0 / data_out_1 / data_out_2  in  8  FIFO x head word, first-word-fall-through: valid whenever empty_x=0, popped by read_enb_x at the clock edge
- read_enb_0 / read_enb_1 / read_enb_2  out  1  pop FIFO x
- soft_reset_0 / soft_reset_1 / soft_reset_2  out  1  one-cycle flush pulse to FIFO x on abort
- out_data  out  8  merged output byte
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts; a byte transfers when out_valid && out_ready
- out_last  out  1  current byte is the packet's parity byte
- grant  out  2  FIFO currently owned (0..2); meaningful while busy=1
- busy  out  1  state is SEND or ABORT

## Operation
- Packet format in each FIFO: header (bits [7:2] = payload length L, 0..63; [1:0] ignored), L payload bytes, 1 parity byte; total L+2 bytes.
- States: IDLE, SEND, ABORT.
- IDLE: if any empty_x=0, pick first non-empty FIFO scanning from (last+1) mod 3 upward with wrap; register grant and go to SEND; else stay. Simultaneous requests resolved only by this scan.
- SEND: out_valid = !empty_grant; out_data = data_out_grant; read_enb_grant = out_valid && out_ready; other read enables 0.
  - First transfer (header): load remaining = L+1.
  - Later transfers: remaining decrements by 1.
  - out_last = 1 when header already taken and remaining == 1.
  - Transfer with out_last=1: go to IDLE, last <= grant.
  - L=0: header then parity byte, out_last on the second byte.
- Watchdog: stall counter clears on every transfer and on SEND entry, increments each SEND cycle without a transfer (FIFO empty or out_ready=0). A non-transfer cycle when counter == TIMEOUT-1 goes to ABORT.
- ABORT: soft_reset_grant = 1 for exactly one cycle, out_valid = 0, read enables 0; next IDLE, last <= grant.
- out_valid never asserts in IDLE or ABORT; out_data is don't-care when out_valid=0 (drive 0).
- Packet boundaries are never violated: no grant change inside SEND.

## Timing
- Reset (async assert, sync release): state IDLE, grant=0, last=2 (FIFO 0 scanned first), remaining=0, stall=0; all read_enb, soft_reset, out_valid, out_last, busy = 0; out_data = 0.
- Arbitration latency: empty_x falls in cycle t while IDLE -> grant/busy valid and out_valid=1 in t+1.
- Throughput: 1 byte/cycle while FIFO non-empty and out_ready=1; one IDLE cycle between packets (L+3 cycles per packet at full rate).
- read_enb_x is combinational from registered state, empty_x and out_ready; no registered lag.
- out_valid may drop mid-packet if FIFO goes empty; data holds packet order regardless.
- Abort: with TIMEOUT=30 and a permanent stall starting in SEND cycle s, soft_reset pulses in cycle s+30, IDLE in s+31.
- Reset mid-packet: immediate return to reset values; remaining FIFO bytes are not flushed by this block.

## Test plan
- Single packet: FIFO1 holds header 0x0D (L=3), 0xA1,0xA2,0xA3, parity 0x5E, out_ready=1 -> grant=1, out_data 0x0D,A1,A2,A3,5E on 5 consecutive cycles, out_last only on 0x5E, then busy=0.
- Round robin: all three FIFOs loaded with L=1 packets at reset release -> packet order FIFO 0,1,2,0 ...; each packet 3 bytes, 1 idle cycle between.
- Backpressure: out_ready toggles 1,0,1,0 during L=4 packet -> no byte lost or duplicated, read_enb only on out_ready=1 cycles, 6 bytes total.
- Watchdog: FIFO2 header L=5 but only 2 payload bytes present, TIMEOUT=30 -> after 30 stall cycles soft_reset_2 high one cycle, no other soft_reset, IDLE next, next grant scan starts at FIFO 0.
- Zero length: header 0x00 then parity 0xFF -> 2 bytes, out_last on 0xFF.
- Reset mid-packet: resetn low during payload byte 2 -> all outputs 0 same cycle (async), after release FIFO 0 scanned first.

Source files
------------

// File: rtl/router_out_arbiter.sv
// router_out_arbiter
//   Packet-level round-robin arbiter merging the three destination FIFOs of
//   the 1x3 router onto a single 8-bit output stream. One FIFO is owned for a
//   whole packet (header, L payload bytes, parity). The header's bits [7:2]
//   give the payload length. A stall watchdog aborts a packet that stops
//   moving for TIMEOUT cycles and pulses that FIFO's soft reset.
//
// Ports
//   clock, resetn              : clock (rising edge), async active-low reset
//   empty_0..2                 : FIFO x empty
//   data_out_0..2              : FIFO x head word (first-word-fall-through)
//   read_enb_0..2              : pop FIFO x (combinational, same-cycle)
//   soft_reset_0..2            : one-cycle flush pulse to FIFO x on abort
//   out_data/out_valid/out_last: merged stream; out_last marks the parity byte
//   out_ready                  : downstream accept
//   grant                      : FIFO currently owned (valid while busy)
//   busy                       : arbiter is in SEND or ABORT
module router_out_arbiter #(
  parameter int unsigned TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic [7:0] data_out_0,
  input  logic [7:0] data_out_1,
  input  logic [7:0] data_out_2,
  output logic       read_enb_0,
  output logic       read_enb_1,
  output logic       read_enb_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [1:0] grant,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    ABORT = 2'd2
  } state_t;

  localparam logic [7:0] STALL_MAX = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [1:0] grant_q, grant_nxt;
  logic [1:0] last_q, last_nxt;
  logic [6:0] remaining, remaining_nxt;
  logic       hdr_taken, hdr_taken_nxt;
  logic [7:0] stall, stall_nxt;

  logic [2:0] rd_vec;
  logic [2:0] sr_vec;
  logic       sel_empty;
  logic [7:0] sel_data;
  logic       xfer;
  logic [1:0] scan0, scan1, scan2;
  logic       any_req;
  logic [1:0] pick;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic is_empty(input logic [1:0] idx,
                                    input logic e0, input logic e1,
                                    input logic e2);
    logic r;
    case (idx)
      2'd0:    r = e0;
      2'd1:    r = e1;
      2'd2:    r = e2;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Head-of-line view of the owned FIFO
  always_comb begin
    sel_empty = is_empty(grant_q, empty_0, empty_1, empty_2);
    case (grant_q)
      2'd0:    sel_data = data_out_0;
      2'd1:    sel_data = data_out_1;
      2'd2:    sel_data = data_out_2;
      default: sel_data = '0;
    endcase
  end

  // Round-robin scan starting one past the last served FIFO
  always_comb begin
    scan0   = inc3(last_q);
    scan1   = inc3(scan0);
    scan2   = inc3(scan1);
    any_req = 1'b1;
    pick    = scan0;
    if (!is_empty(scan0, empty_0, empty_1, empty_2)) begin
      pick = scan0;
    end else if (!is_empty(scan1, empty_0, empty_1, empty_2)) begin
      pick = scan1;
    end else if (!is_empty(scan2, empty_0, empty_1, empty_2)) begin
      pick = scan2;
    end else begin
      any_req = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      grant_q   <= '0;
      last_q    <= 2'd2;
      remaining <= '0;
      hdr_taken <= 1'b0;
      stall     <= '0;
    end else begin
      state     <= state_nxt;
      grant_q   <= grant_nxt;
      last_q    <= last_nxt;
      remaining <= remaining_nxt;
      hdr_taken <= hdr_taken_nxt;
      stall     <= stall_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant_q;
    last_nxt      = last_q;
    remaining_nxt = remaining;
    hdr_taken_nxt = hdr_taken;
    stall_nxt     = stall;
    rd_vec        = '0;
    sr_vec        = '0;
    out_valid     = 1'b0;
    out_data      = '0;
    out_last      = 1'b0;
    xfer          = 1'b0;

    case (state)
      IDLE: begin
        if (any_req) begin
          grant_nxt     = pick;
          state_nxt     = SEND;
          stall_nxt     = '0;
          hdr_taken_nxt = 1'b0;
          remaining_nxt = '0;
        end
      end

      SEND: begin
        out_valid = !sel_empty;
        xfer      = out_valid && out_ready;
        out_data  = out_valid ? sel_data : '0;
        out_last  = hdr_taken && (remaining == 7'd1);
        rd_vec[grant_q] = xfer;

        if (xfer) begin
          stall_nxt = '0;
          if (!hdr_taken) begin
            // payload bytes plus the trailing parity byte
            remaining_nxt = {1'b0, sel_data[7:2]} + 7'd1;
            hdr_taken_nxt = 1'b1;
          end else begin
            remaining_nxt = remaining - 7'd1;
          end
          if (out_last) begin
            state_nxt     = IDLE;
            last_nxt      = grant_q;
            hdr_taken_nxt = 1'b0;
          end
        end else if (stall == STALL_MAX) begin
          state_nxt = ABORT;
        end else begin
          stall_nxt = stall + 8'd1;
        end
      end

      ABORT: begin
        sr_vec[grant_q] = 1'b1;
        state_nxt       = IDLE;
        last_nxt        = grant_q;
        hdr_taken_nxt   = 1'b0;
        remaining_nxt   = '0;
        stall_nxt       = '0;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign read_enb_0   = rd_vec[0];
  assign read_enb_1   = rd_vec[1];
  assign read_enb_2   = rd_vec[2];
  assign soft_reset_0 = sr_vec[0];
  assign soft_reset_1 = sr_vec[1];
  assign soft_reset_2 = sr_vec[2];
  assign grant        = grant_q;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_router_out_arbiter.sv
module tb_router_out_arbiter;

  logic       clock = 1'b0;
  logic       resetn;
  logic       empty_0, empty_1, empty_2;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [1:0] grant;
  logic       busy;

  always #5 clock = ~clock;

  router_out_arbiter #(.TIMEOUT(30)) dut (
    .clock(clock), .resetn(resetn),
    .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .grant(grant), .busy(busy)
  );

  // First-word-fall-through FIFO models
  logic [7:0] fm [3][256];
  logic [7:0] wp [3];
  logic [7:0] rp [3];

  assign empty_0    = (wp[0] == rp[0]);
  assign empty_1    = (wp[1] == rp[1]);
  assign empty_2    = (wp[2] == rp[2]);
  assign data_out_0 = fm[0][rp[0]];
  assign data_out_1 = fm[1][rp[1]];
  assign data_out_2 = fm[2][rp[2]];

  always @(posedge clock) begin
    if (soft_reset_0) rp[0] <= wp[0]; else if (read_enb_0) rp[0] <= rp[0] + 8'd1;
    if (soft_reset_1) rp[1] <= wp[1]; else if (read_enb_1) rp[1] <= rp[1] + 8'd1;
    if (soft_reset_2) rp[2] <= wp[2]; else if (read_enb_2) rp[2] <= rp[2] + 8'd1;
  end

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [1:0] gnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   xfers  = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input int f, input logic [7:0] b, input logic last);
    exp_t e;
    fm[f][wp[f]] = b;
    wp[f] = wp[f] + 8'd1;
    e.data = b;
    e.last = last;
    e.gnt  = 2'(f);
    exp_q.push_back(e);
  endtask

  // Adds a byte to a FIFO without expecting it on the output
  task automatic push_only(input int f, input logic [7:0] b);
    fm[f][wp[f]] = b;
    wp[f] = wp[f] + 8'd1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Runs n cycles from the current cycle (index 0), recording busy activity
  task automatic run(input int n, output int n_busy, output int span);
    int first_b, last_b;
    n_busy = 0; first_b = 0; last_b = -1;
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      if (busy) begin
        if (n_busy == 0) first_b = c;
        n_busy++;
        last_b = c;
      end
      @(posedge clock);
      #1;
    end
    span = last_b - first_b + 1;
  endtask

  // Scoreboard monitor
  initial begin
    exp_t       e;
    logic [2:0] rd;
    forever begin
      @(negedge clock);
      rd = {read_enb_2, read_enb_1, read_enb_0};
      if (resetn) begin
        if (out_valid && out_ready) begin
          xfers++;
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", int'(out_data), -1);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", int'(out_data), int'(e.data));
            chk("out_last", int'(out_last), int'(e.last));
            chk("grant", int'(grant), int'(e.gnt));
            chk("read_enb_xfer", int'(rd), int'(3'b001 << e.gnt));
          end
        end else if (busy) begin
          chk("read_enb_idle", int'(rd), 0);
        end
      end
    end
  end

  initial begin
    int nb, sp, x0;
    int sr_cnt, sr_cyc, other_sr;
    logic b34, b35, v34;

    for (int f = 0; f < 3; f++) begin
      wp[f] = '0;
      rp[f] = '0;
    end
    resetn    = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    chk("reset_outputs",
        int'({read_enb_0, read_enb_1, read_enb_2, soft_reset_0, soft_reset_1,
              soft_reset_2, out_valid, out_last, busy, grant, out_data}), 0);
    tick(1);
    resetn = 1'b1;
    tick(1);

    // Single packet on FIFO 1
    push(1, 8'h0D, 1'b0); push(1, 8'hA1, 1'b0); push(1, 8'hA2, 1'b0);
    push(1, 8'hA3, 1'b0); push(1, 8'h5E, 1'b1);
    run(12, nb, sp);
    chk("single_busy_cycles", nb, 5);
    chk("single_busy_span", sp, 5);

    // Round robin, loaded while in reset
    resetn = 1'b0;
    push(0, 8'h04, 1'b0); push(0, 8'h11, 1'b0); push(0, 8'hE1, 1'b1);
    push(1, 8'h04, 1'b0); push(1, 8'h22, 1'b0); push(1, 8'hE2, 1'b1);
    push(2, 8'h04, 1'b0); push(2, 8'h33, 1'b0); push(2, 8'hE3, 1'b1);
    push(0, 8'h04, 1'b0); push(0, 8'h44, 1'b0); push(0, 8'hE4, 1'b1);
    tick(1);
    resetn = 1'b1;
    run(24, nb, sp);
    chk("rr_busy_cycles", nb, 12);
    chk("rr_busy_span", sp, 15);

    // Backpressure, L=4 on FIFO 2 (scan starts at FIFO 1 after FIFO 0)
    x0 = xfers;
    push(2, 8'h10, 1'b0); push(2, 8'hB1, 1'b0); push(2, 8'hB2, 1'b0);
    push(2, 8'hB3, 1'b0); push(2, 8'hB4, 1'b0); push(2, 8'h77, 1'b1);
    for (int c = 0; c < 20; c++) begin
      out_ready = (c % 2 == 0);
      tick(1);
    end
    out_ready = 1'b1;
    tick(2);
    chk("bp_transfers", xfers - x0, 6);

    // Watchdog: header claims L=5, only two payload bytes ever arrive
    push(2, 8'h14, 1'b0); push(2, 8'hC1, 1'b0); push(2, 8'hC2, 1'b0);
    sr_cnt = 0; sr_cyc = -1; other_sr = 0; b34 = 1'b0; b35 = 1'b1; v34 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (soft_reset_2) begin
        sr_cnt++;
        sr_cyc = c;
      end
      if (soft_reset_0 || soft_reset_1) other_sr++;
      if (c == 34) begin
        b34 = busy;
        v34 = out_valid;
      end
      if (c == 35) b35 = busy;
      @(posedge clock);
      #1;
    end
    chk("wd_pulse_count", sr_cnt, 1);
    chk("wd_pulse_cycle", sr_cyc, 34);
    chk("wd_other_soft_reset", other_sr, 0);
    chk("wd_abort_busy", int'(b34), 1);
    chk("wd_abort_valid", int'(v34), 0);
    chk("wd_idle_after", int'(b35), 0);

    // Zero-length packets; scan after the abort must start at FIFO 0
    push(0, 8'h00, 1'b0); push(0, 8'h11, 1'b1);
    push(1, 8'h00, 1'b0); push(1, 8'hFF, 1'b1);
    run(10, nb, sp);
    chk("zero_len_busy_cycles", nb, 4);

    // Reset during payload byte 2 of a FIFO 0 packet
    push(0, 8'h0C, 1'b0); push(0, 8'hD1, 1'b0);
    push_only(0, 8'hD2); push_only(0, 8'hD3); push_only(0, 8'h99);
    tick(3);
    resetn = 1'b0;
    #1;
    chk("midreset_outputs",
        int'({read_enb_0, read_enb_1, read_enb_2, soft_reset_0, soft_reset_1,
              soft_reset_2, out_valid, out_last, busy, grant, out_data}), 0);
    // This block does not flush; the bench discards the orphaned bytes
    wp[0] = rp[0];
    push(0, 8'h00, 1'b0); push(0, 8'hAA, 1'b1);
    push(2, 8'h00, 1'b0); push(2, 8'hBB, 1'b1);
    tick(1);
    resetn = 1'b1;
    run(12, nb, sp);
    chk("post_reset_busy_cycles", nb, 4);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
